// File: rtl/chacha_seq_pkg.sv
// chacha_seq_pkg: register map, control codes and FSM states for the chacha bus sequencer
package chacha_seq_pkg;
  localparam logic [7:0] ADDR_CTRL   = 8'h08;
  localparam logic [7:0] ADDR_KEY0   = 8'h10;
  localparam logic [7:0] ADDR_NONCE0 = 8'h20;
  localparam logic [7:0] ADDR_DATA   = 8'h30;
  localparam logic [7:0] ADDR_TAG    = 8'h40;
  localparam logic [7:0] CTRL_INIT   = 8'h01;
  localparam logic [7:0] CTRL_NEXT   = 8'h02;
  localparam logic [7:0] CTRL_DONE   = 8'h04;
  typedef enum logic [3:0] {
    IDLE, KEY, NONCE, WAIT_IN, WR_DATA, INIT, NEXT, WAIT, DONE, RD_DATA, RD_TAG, OUT
  } state_t;
endpackage

// File: rtl/chacha_bus_slot.sv
// chacha_bus_slot: 2-cycle strobe/gap bus slot generator with read-capture timing
// Ports: req/we/addr/wdata describe the access wanted this slot; bus_* drive the slave;
// slot_done marks the gap cycle, cap marks the gap cycle of a read (bus_rdata valid).
module chacha_bus_slot #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 512
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              slot_done,
  output logic              cap,
  output logic              bus_cs,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata
);
  logic phase;
  always_ff @(posedge clk) phase <= rst ? 1'b0 : req & ~phase;
  assign bus_cs    = req & ~phase;
  assign bus_we    = bus_cs & we;
  assign bus_addr  = bus_cs ? addr : '0;
  assign bus_wdata = bus_we ? wdata : '0;
  assign slot_done = req & phase;
  assign cap       = slot_done & ~we;
endmodule

// File: rtl/chacha_bus_sequencer.sv
// chacha_bus_sequencer: drives the chacha20_poly1305 register sequence from a key/nonce config and a plaintext block stream
// Ports: cfg_* opens a message; in_* plaintext stream; out_* ciphertext/tag stream; bus_* slave master port.
// Optional CHACHA_SEQ_PERF_CNT_EN adds saturating perf_blocks/perf_cycles counters.
module chacha_bus_sequencer
  import chacha_seq_pkg::*;
#(
  parameter int WAIT_CYCLES = 5,
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 512
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_start,
  input  logic [255:0]      cfg_key,
  input  logic [95:0]       cfg_nonce,
  output logic              busy,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [127:0]      out_tag,
  output logic              out_last,
  output logic              bus_cs,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata
`ifdef CHACHA_SEQ_PERF_CNT_EN
  ,
  output logic [31:0]       perf_blocks,
  output logic [31:0]       perf_cycles
`endif
);
  localparam logic [7:0] WAIT_LAST = 8'(WAIT_CYCLES - 1);
  state_t state, state_n;
  logic [7:0] cnt, cnt_n;
  logic [255:0] key_q;
  logic [95:0] nonce_q;
  logic [DATA_W-1:0] blk_q;
  logic last_q;
  logic req, we, slot_done, cap;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (cfg_start) state_n = KEY;
      KEY:     if (slot_done && cnt == 8'd7) state_n = NONCE;
      NONCE:   if (slot_done && cnt == 8'd2) state_n = WAIT_IN;
      WAIT_IN: if (in_valid) state_n = WR_DATA;
      WR_DATA: if (slot_done) state_n = INIT;
      INIT:    if (slot_done) state_n = NEXT;
      NEXT:    if (slot_done) state_n = WAIT;
      WAIT:    if (cnt == WAIT_LAST) state_n = DONE;
      DONE:    if (slot_done) state_n = RD_DATA;
      RD_DATA: if (slot_done) state_n = RD_TAG;
      RD_TAG:  if (slot_done) state_n = OUT;
      OUT:     if (out_ready) state_n = last_q ? IDLE : WAIT_IN;
      default: state_n = IDLE;
    endcase
    // cnt indexes key/nonce words per completed slot and times WAIT; cleared on every state change
    cnt_n = state_n != state ? '0 : (state == WAIT || slot_done) ? cnt + 8'd1 : cnt;
  end
  always_comb begin
    req   = 1'b1;
    we    = 1'b1;
    addr  = '0;
    wdata = '0;
    case (state)
      KEY:     begin addr = ADDR_W'(ADDR_KEY0 + cnt); wdata = DATA_W'(key_q[32*cnt[2:0] +: 32]); end
      NONCE:   begin addr = ADDR_W'(ADDR_NONCE0 + cnt); wdata = DATA_W'(nonce_q[32*cnt[1:0] +: 32]); end
      WR_DATA: begin addr = ADDR_W'(ADDR_DATA); wdata = blk_q; end
      INIT:    begin addr = ADDR_W'(ADDR_CTRL); wdata = DATA_W'(CTRL_INIT); end
      NEXT:    begin addr = ADDR_W'(ADDR_CTRL); wdata = DATA_W'(CTRL_NEXT); end
      DONE:    begin addr = ADDR_W'(ADDR_CTRL); wdata = DATA_W'(CTRL_DONE); end
      RD_DATA: begin we = 1'b0; addr = ADDR_W'(ADDR_DATA); end
      RD_TAG:  begin we = 1'b0; addr = ADDR_W'(ADDR_TAG); end
      default: req = 1'b0;
    endcase
  end
  assign busy      = state != IDLE;
  assign in_ready  = state == WAIT_IN;
  assign out_valid = state == OUT;
  assign out_last  = last_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      key_q    <= '0;
      nonce_q  <= '0;
      blk_q    <= '0;
      last_q   <= 1'b0;
      out_data <= '0;
      out_tag  <= '0;
    end else begin
      cnt <= cnt_n;
      if (state == IDLE && cfg_start) begin
        key_q   <= cfg_key;
        nonce_q <= cfg_nonce;
      end
      if (in_valid && in_ready) begin
        blk_q  <= in_data;
        last_q <= in_last;
      end
      if (cap && state == RD_DATA) out_data <= bus_rdata;
      if (cap && state == RD_TAG) out_tag <= bus_rdata[127:0];
    end
  end
  chacha_bus_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .slot_done(slot_done), .cap(cap), .bus_cs(bus_cs), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata)
  );
`ifdef CHACHA_SEQ_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_blocks <= '0;
      perf_cycles <= '0;
    end else begin
      if (out_valid && out_ready && perf_blocks != '1) perf_blocks <= perf_blocks + 32'd1;
      if (busy && perf_cycles != '1) perf_cycles <= perf_cycles + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_chacha_bus_sequencer.sv
// tb_chacha_bus_sequencer: directed self-checking bench for chacha_bus_sequencer with a simple slave model
module tb_chacha_bus_sequencer;
  localparam logic [511:0] MASK = {16{32'ha5a55a5a}};
  localparam logic [255:0] KEY_A = 256'h00112233_44556677_8899aabb_ccddeeff_01234567_89abcdef_fedcba98_76543210;
  localparam logic [95:0] NONCE_A = 96'h33333333_22222222_11111111;
  logic clk = 0, rst = 1, cfg_start = 0, in_valid = 0, in_last = 0, out_ready = 0;
  logic [255:0] cfg_key = '0;
  logic [95:0] cfg_nonce = '0;
  logic [511:0] in_data = '0, bus_rdata = '0, out_data, bus_wdata;
  logic [127:0] out_tag;
  logic busy, in_ready, out_valid, out_last, bus_cs, bus_we;
  logic [7:0] bus_addr;
`ifdef CHACHA_SEQ_PERF_CNT_EN
  logic [31:0] perf_blocks, perf_cycles;
`endif
  int checks = 0, failures = 0, cyc = 0, b2b = 0, both = 0;
  logic prev_cs = 0;
  typedef struct {logic we; logic [7:0] addr; logic [511:0] wd; int cyc;} stb_t;
  stb_t q[$];
  logic [511:0] s_data = '0, s_ct = '0;
  logic [127:0] s_tag = '0;
  chacha_bus_sequencer dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_key(cfg_key), .cfg_nonce(cfg_nonce),
    .busy(busy), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
    .out_last(out_last), .bus_cs(bus_cs), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata)
`ifdef CHACHA_SEQ_PERF_CNT_EN
    , .perf_blocks(perf_blocks), .perf_cycles(perf_cycles)
`endif
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // slave: ciphertext/tag are only produced by the DONE write, and read data lags the strobe by one cycle
  always @(posedge clk) begin
    if (bus_cs && bus_we && bus_addr == 8'h30) s_data <= bus_wdata;
    if (bus_cs && bus_we && bus_addr == 8'h08 && bus_wdata == 512'd4) begin
      s_ct  <= s_data ^ MASK;
      s_tag <= s_data[511:384] ^ 128'h1;
    end
    if (bus_cs && !bus_we) bus_rdata <= bus_addr == 8'h30 ? s_ct : {384'b0, s_tag};
  end
  always @(negedge clk) begin
    if (bus_cs) q.push_back('{bus_we, bus_addr, bus_wdata, cyc});
    if (bus_cs && prev_cs) b2b++;
    if (in_ready && out_valid) both++;
    prev_cs = bus_cs;
  end
  task automatic wait_ready;
    int t = 0;
    while (!in_ready && t < 300) begin @(negedge clk); t++; end
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL wait_ready in_ready=%b required 1 after %0d cycles", in_ready, t); end
  endtask
  task automatic cfg(input logic [255:0] k, input logic [95:0] n);
    @(negedge clk);
    cfg_key = k; cfg_nonce = n; cfg_start = 1;
    @(negedge clk);
    cfg_start = 0;
    wait_ready;
  endtask
  task automatic send_block(input logic [511:0] d, input logic last);
    int lat = 0;
    logic rdy_bad = 0;
    in_data = d; in_last = last; in_valid = 1;
    wait_ready;
    @(posedge clk);
    @(negedge clk);
    in_valid = 0;
    while (!out_valid && lat < 300) begin
      if (in_ready) rdy_bad = 1;
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== 17) begin failures++; $display("FAIL latency got=%0d required=17", lat); end
    checks++;
    if (out_data !== (d ^ MASK)) begin failures++; $display("FAIL out_data got=%h required=%h", out_data, d ^ MASK); end
    checks++;
    if (out_tag !== (d[511:384] ^ 128'h1)) begin failures++; $display("FAIL out_tag got=%h required=%h", out_tag, d[511:384] ^ 128'h1); end
    checks++;
    if (out_last !== last || rdy_bad !== 1'b0) begin failures++; $display("FAIL out_last/in_ready out_last=%b required=%b in_ready_seen=%b required=0", out_last, last, rdy_bad); end
  endtask
  task automatic accept(input logic last);
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    checks++;
    if (busy !== !last || in_ready !== !last) begin failures++; $display("FAIL accept busy=%b in_ready=%b required=%b", busy, in_ready, !last); end
  endtask
  task automatic test_reset;
    rst = 1; cfg_start = 1;
    repeat (3) @(negedge clk);
    rst = 0; cfg_start = 0;
    checks++;
    if ({busy, bus_cs, bus_we, bus_addr, in_ready, out_valid, out_last} !== '0) begin
      failures++; $display("FAIL reset_ctrl got=%b required=0", {busy, bus_cs, bus_we, bus_addr, in_ready, out_valid, out_last});
    end
    checks++;
    if (bus_wdata !== '0 || out_data !== '0 || out_tag !== '0) begin
      failures++; $display("FAIL reset_data wdata=%h out_data=%h out_tag=%h required 0", bus_wdata, out_data, out_tag);
    end
  endtask
  task automatic test_config;
    logic [7:0] ea[11] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h20, 8'h21, 8'h22};
    logic [31:0] ew[11] = '{32'h76543210, 32'hfedcba98, 32'h89abcdef, 32'h01234567, 32'hccddeeff,
                            32'h8899aabb, 32'h44556677, 32'h00112233, 32'h11111111, 32'h22222222, 32'h33333333};
    q.delete();
    cfg(KEY_A, NONCE_A);
    checks++;
    if (q.size() !== 11 || busy !== 1'b1) begin failures++; $display("FAIL cfg_count strobes=%0d busy=%b required 11/1", q.size(), busy); end
    for (int i = 0; i < 11 && i < q.size(); i++) begin
      checks++;
      if (q[i].we !== 1'b1 || q[i].addr !== ea[i] || q[i].wd !== {480'b0, ew[i]}) begin
        failures++; $display("FAIL cfg_strobe%0d we=%b addr=%h wd=%h required 1/%h/%h", i, q[i].we, q[i].addr, q[i].wd[31:0], ea[i], ew[i]);
      end
    end
    checks++;
    if (b2b !== 0) begin failures++; $display("FAIL cfg_gap back_to_back=%0d required 0", b2b); end
  endtask
  task automatic test_single;
    logic [511:0] d = {16{32'hdeadbeef}};
    logic [7:0] ea[6] = '{8'h30, 8'h08, 8'h08, 8'h08, 8'h30, 8'h40};
    logic ewe[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [511:0] ew[4];
    ew[0] = d; ew[1] = 512'd1; ew[2] = 512'd2; ew[3] = 512'd4;
    q.delete();
    send_block(d, 1'b1);
    checks++;
    if (q.size() !== 6) begin failures++; $display("FAIL single_count strobes=%0d required 6", q.size()); end
    for (int i = 0; i < 6 && i < q.size(); i++) begin
      checks++;
      if (q[i].we !== ewe[i] || q[i].addr !== ea[i] || (i < 4 && q[i].wd !== ew[i])) begin
        failures++; $display("FAIL single_strobe%0d we=%b addr=%h wd=%h required %b/%h", i, q[i].we, q[i].addr, q[i].wd[31:0], ewe[i], ea[i]);
      end
    end
    if (q.size() >= 4) begin
      checks++;
      if (q[3].cyc - q[2].cyc !== 7) begin failures++; $display("FAIL wait_gap got=%0d required=7", q[3].cyc - q[2].cyc); end
    end
    accept(1'b1);
  endtask
  task automatic test_back_to_back;
    @(negedge clk); rst = 1; @(negedge clk); rst = 0;
    cfg(KEY_A, NONCE_A);
    for (int k = 0; k < 10; k++) begin
      send_block({16{32'hdeadbeef + k}}, k == 9);
      accept(k == 9);
    end
`ifdef CHACHA_SEQ_PERF_CNT_EN
    checks++;
    if (perf_blocks !== 32'd10) begin failures++; $display("FAIL perf_blocks got=%0d required=10", perf_blocks); end
`endif
    checks++;
    if (b2b !== 0 || both !== 0) begin failures++; $display("FAIL stream_rules back_to_back=%0d ready_with_valid=%0d required 0/0", b2b, both); end
  endtask
  task automatic test_stall;
    logic [511:0] d = {8{64'h0123456789abcdef}};
    int n;
    logic bad = 0;
    cfg(KEY_A, ~NONCE_A);
    send_block(d, 1'b1);
    n = q.size();
    repeat (20) begin
      @(negedge clk);
      if (!out_valid || out_data !== (d ^ MASK) || out_tag !== (d[511:384] ^ 128'h1) || in_ready) bad = 1;
    end
    checks++;
    if (bad !== 1'b0 || q.size() !== n) begin failures++; $display("FAIL stall unstable=%b new_strobes=%0d required 0/0", bad, q.size() - n); end
    accept(1'b1);
  endtask
  task automatic test_reset_mid;
    int n;
    cfg(~KEY_A, NONCE_A);
    n = q.size();
    @(negedge clk); cfg_start = 1; @(negedge clk); cfg_start = 0;
    repeat (4) @(negedge clk);
    checks++;
    if (q.size() !== n || in_ready !== 1'b1) begin failures++; $display("FAIL cfg_while_busy new_strobes=%0d in_ready=%b required 0/1", q.size() - n, in_ready); end
    for (int k = 0; k < 2; k++) begin send_block({16{32'h1000 + k}}, 1'b0); accept(1'b0); end
    in_data = {16{32'h2000}}; in_last = 0; in_valid = 1;
    wait_ready;
    @(posedge clk); @(negedge clk);
    in_valid = 0;
    repeat (7) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    checks++;
    if ({busy, bus_cs, bus_we, bus_addr, in_ready, out_valid, out_last} !== '0 || bus_wdata !== '0 || out_data !== '0 || out_tag !== '0) begin
      failures++; $display("FAIL reset_mid ctrl=%b required all zero", {busy, bus_cs, bus_we, bus_addr, in_ready, out_valid, out_last});
    end
    n = q.size();
    repeat (5) @(negedge clk);
    checks++;
    if (q.size() !== n || busy !== 1'b0) begin failures++; $display("FAIL reset_quiet strobes=%0d busy=%b required 0/0", q.size() - n, busy); end
    q.delete();
    cfg(KEY_A, NONCE_A);
    checks++;
    if (q.size() !== 11 || (q.size() > 0 && q[0].addr !== 8'h10)) begin failures++; $display("FAIL restart strobes=%0d required 11 from addr 10", q.size()); end
  endtask
  initial begin
    test_reset;
    test_config;
    test_single;
    test_back_to_back;
    test_stall;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/chacha_bus_sequencer.md
Name: chacha_bus_sequencer

Overview:
- Upstream bus master for the chacha20_poly1305_bus register interface.
- Converts a key/nonce config handshake plus a stream of 512-bit plaintext blocks into the exact register write/read sequence the core requires.
- Returns ciphertext blocks and the tag on a valid/ready output stream.
- Sits between the DMA/stream fabric and the crypto bus slave; removes software-driven sequencing.

Parameters:
- WAIT_CYCLES, 5: idle cycles between the NEXT write and the DONE write (encryption time); legal range 1..255.
- ADDR_W, 8: bus address width.
- DATA_W, 512: bus data width.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- cfg_start  in  1  one-cycle pulse; load key/nonce and open a message.
- cfg_key  in  256  key; word i = bits [32i+31:32i].
- cfg_nonce  in  96  nonce; word j = bits [32j+31:32j].
- busy  out  1  high from accepted cfg_start until the last block is delivered.
- in_valid  in  1  plaintext block valid.
- in_ready  out  1  sequencer accepts a block.
- in_data  in  512  plaintext block.
- in_last  in  1  final block of the message.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  512  ciphertext block (bus read of 0x30).
- out_tag  out  128  low 128 bits of bus read of 0x40.
- out_last  out  1  in_last of the originating block.
- bus_cs  out  1  slave chip select.
- bus_we  out  1  slave write enable.
- bus_addr  out  ADDR_W  slave address.
- bus_wdata  out  DATA_W  slave write data.
- bus_rdata  in  DATA_W  slave read data; valid the cycle after a read strobe.

Behaviour:
- Reset values: bus_cs=0, bus_we=0, bus_addr=0, bus_wdata=0, in_ready=0, out_valid=0, out_data=0, out_tag=0, out_last=0, busy=0. FSM returns to IDLE.
- Reset mid-operation abandons the transaction with no further strobes. The slave is left as is; the next message rewrites key and nonce.
- Bus access is a 2-cycle slot: strobe cycle (cs=1, addr/we/wdata set) followed by a gap cycle (cs=0, we=0).
  - Read data is captured on the gap cycle.
  - Strobes are never back-to-back.
- FSM states: IDLE, KEY, NONCE, WAIT_IN, WR_DATA, INIT, NEXT, WAIT, DONE, RD_DATA, RD_TAG, OUT.
- IDLE: on cfg_start, register key and nonce, set busy=1, go to KEY.
- KEY: 8 slots writing addr 0x10+i, wdata = zero-extended key word i, i = 0..7. Then go to NONCE.
- NONCE: 3 slots writing addr 0x20+j with nonce word j. Then go to WAIT_IN.
- WAIT_IN: in_ready=1. On in_valid&&in_ready, register in_data and in_last, then go to WR_DATA.
- WR_DATA: write 0x30 = block.
- INIT: write 0x08 = 1.
- NEXT: write 0x08 = 2.
- WAIT: 8-bit counter runs WAIT_CYCLES cycles with cs=0.
- DONE: write 0x08 = 4.
- RD_DATA: read 0x30, capture into out_data.
- RD_TAG: read 0x40, capture bits [127:0] into out_tag.
- OUT: out_valid=1, outputs held stable until out_ready.
  - On acceptance, if out_last: busy=0 and go to IDLE; else go to WAIT_IN.
- Per-block latency from input acceptance to out_valid is exactly 12 + WAIT_CYCLES cycles. With the default this is 17.
- cfg_start while busy is ignored.
- in_valid outside WAIT_IN is not accepted.
- in_ready is never asserted in the same cycle as out_valid.
- cfg_start and a reset asserted together: reset wins.

Optional Feature:
- Macro CHACHA_SEQ_PERF_CNT_EN.
- When defined, adds outputs perf_blocks (32, blocks completed since reset) and perf_cycles (32, cycles with busy=1). Both are saturating and cleared by rst.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package chacha_seq_pkg holds:
  - register address constants: ADDR_CTRL=0x08, ADDR_KEY0=0x10, ADDR_NONCE0=0x20, ADDR_DATA=0x30, ADDR_TAG=0x40;
  - control codes CTRL_INIT=1, CTRL_NEXT=2, CTRL_DONE=4;
  - the FSM state enum.
- One natural sub-module, chacha_bus_slot: generates the 2-cycle strobe/gap slot and the read capture, and returns slot_done.

Test Plan:
- Reset, then cfg_start with key 00112233..76543210 and nonce 11111111/22222222/33333333 → exactly 11 write strobes, to 0x10..0x17 then 0x20..0x22, with matching words; each strobe followed by cs=0.
- One block deadbeef×16 with in_last=1 against a slave model → strobe sequence 30w, 08w=1, 08w=2, 5 idle cycles, 08w=4, 30r, 40r; out_valid exactly 17 cycles after acceptance; out_last=1; busy drops on acceptance.
- 10 blocks deadbeef+k → 10 results in order; in_ready low throughout each block's processing.
- Hold out_ready=0 for 20 cycles → out_data/out_tag stable, no bus strobes, in_ready=0.
- Assert rst during WAIT of block 3 → next cycle all outputs at reset values, busy=0; a new cfg_start restarts from KEY.
- With CHACHA_SEQ_PERF_CNT_EN defined, after the 10-block run → perf_blocks=10.
